// File: rtl/serial_magnitude_compare.sv
// Serial MSB-first unsigned magnitude comparator: one bit-compare slice evaluated per clock.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_magnitude_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             valid,
  output logic             bit_a,
  output logic             bit_b
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             e_r, g_r;
  logic             x, y, e_nx, g_nx;
  logic             accept, last;

  // Slice equations for the bit currently addressed by cnt.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    x      = sa[cnt];
    y      = sb[cnt];
    e_nx   = e_r & ~(x ^ y);
    g_nx   = g_r | (e_r & x & ~y);
    accept = start && (state == IDLE || state == DONE);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    last   = (cnt == '0) || !e_nx;
`else
    last   = (cnt == '0);
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = accept ? SHIFT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    bit_a = busy & x;
    bit_b = busy & y;
  end

  always_ff @(posedge clk) begin
    // NOTE: operand registers are reset as well, so a post-reset state is fully known.
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      e_r   <= 1'b0;
      g_r   <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      valid <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      cnt   <= CW'(WIDTH - 1);
      e_r   <= 1'b1;
      g_r   <= 1'b0;
      valid <= 1'b0;
    end else if (state == SHIFT) begin
      e_r <= e_nx;
      g_r <= g_nx;
      cnt <= cnt - CW'(1);
      // Publish the result on the final edge so it is registered during DONE.
      if (last) begin
        eq    <= e_nx;
        gt    <= g_nx;
        lt    <= ~e_nx & ~g_nx;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Randomized self-checking bench for serial_magnitude_compare against an arithmetic reference.
// Define SERIAL_CMP_EARLY_EXIT_EN for both RTL and bench to exercise the early-exit build.
module tb_serial_magnitude_compare;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, eq, gt, lt, valid, bit_a, bit_b;

  int checks   = 0;
  int failures = 0;

  serial_magnitude_compare #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt),
    .valid (valid),
    .bit_a (bit_a),
    .bit_b (bit_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cycles from accept to done, from the data alone.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--)
      if (x[i] != y[i]) return W - i;
`endif
    return W;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done from just after the accepting edge; checks busy and the bit taps on the way.
  task automatic wait_done(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input bit disturb, output int n);
    n = 0;
    while (!done && n < W + 4) begin
      check("busy", busy, 1);
      if (n < W) begin
        check("bit_a", bit_a, av[W-1-n]);
        check("bit_b", bit_b, bv[W-1-n]);
      end
      if (disturb && n == 2) begin
        start = 1'b1;
        a     = 8'h00;
        b     = W'($urandom);
      end else if (disturb) begin
        start = 1'b0;
      end
      tick();
      n++;
    end
  endtask

  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit disturb);
    int n;
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    a     = ~av;
    b     = W'($urandom);
    check("valid_drop", valid, 0);
    wait_done(av, bv, disturb, n);
    check("latency", n, exp_lat(av, bv));
    check("done", done, 1);
    check("valid", valid, 1);
    check("eq", eq, av == bv);
    check("gt", gt, av > bv);
    check("lt", lt, av < bv);
    tick();
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("valid_hold", valid, 1);
    check("eq_hold", eq, av == bv);
    check("gt_hold", gt, av > bv);
  endtask

  initial begin
    int n, dones;
    logic [W-1:0] ra, rb;

    rst   = 1'b1;
    start = 1'b1;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_outs", {busy, done, eq, gt, lt, valid, bit_a, bit_b}, 8'h00);
    start = 1'b0;
    rst   = 1'b0;

    run_cmp(8'h5A, 8'h5A, 1'b0);

    // Reset in the third cycle of a compare aborts it.
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h5B;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_outs", {busy, done, eq, gt, lt, valid, bit_a, bit_b}, 8'h00);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < W + 3; i++) begin
      dones += int'(done);
      tick();
    end
    check("abort_no_done", dones, 0);

    run_cmp(8'h80, 8'h7F, 1'b0);
    run_cmp(8'h10, 8'h11, 1'b0);
    run_cmp(8'h33, 8'h33, 1'b1);

    // Back-to-back compares with start held high.
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    tick();
    a = 8'h00;
    b = 8'hFF;
    wait_done(8'hFF, 8'h00, 1'b0, n);
    check("b2b1_latency", n, exp_lat(8'hFF, 8'h00));
    check("b2b1_done", done, 1);
    check("b2b1_gt", gt, 1);
    check("b2b1_lt", lt, 0);
    tick();
    start = 1'b0;
    check("b2b_no_gap", busy, 1);
    check("b2b_done_pulse", done, 0);
    check("b2b_valid_drop", valid, 0);
    wait_done(8'h00, 8'hFF, 1'b0, n);
    check("b2b2_latency", n, exp_lat(8'h00, 8'hFF));
    check("b2b2_done", done, 1);
    check("b2b2_lt", lt, 1);
    check("b2b2_gt", gt, 0);
    tick();
    check("b2b2_done_pulse", done, 0);

    // Random operands, biased toward equal and single-bit differences.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_compare.md
Name: serial_magnitude_compare

Overview:
- Sequential, MSB-first magnitude comparator built on the bit-compare-slice chain.
- Loads two WIDTH-bit words and evaluates one bit per clock with the slice equations.
- Keeps the running equal/greater state in registers instead of a ripple chain.
- Feeds downstream control logic with a registered eq/gt/lt result and a one-cycle done strobe.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle strobe; result became valid this cycle.
- eq  output  1  A == B; valid while valid=1.
- gt  output  1  A > B (unsigned); valid while valid=1.
- lt  output  1  A < B (unsigned); valid while valid=1.
- valid  output  1  result registers hold the result of the last completed compare.
- bit_a  output  1  bit of A being evaluated this cycle (debug/slice tap).
- bit_b  output  1  bit of B being evaluated this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - busy, done, eq, gt, lt, valid, bit_a, bit_b all go to 0.
  - Shift registers and the bit counter clear.
  - Reset wins over start. Reset during SHIFT aborts the compare; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures a and b into shift registers.
  - Sets the running registers e_r=1, g_r=0 and cnt=WIDTH-1, then goes to SHIFT.
  - valid drops to 0 on the accepting edge.
- SHIFT:
  - Each edge evaluates bit index cnt: x=sa[cnt], y=sb[cnt].
  - Next e_r = e_r & ~(x ^ y).
  - Next g_r = g_r | (e_r & x & ~y).
  - cnt decrements by 1.
  - bit_a/bit_b combinationally present x/y during SHIFT and are 0 otherwise.
  - start is ignored while in SHIFT.
  - After the edge that evaluates bit 0, go to DONE.
- DONE (exactly one cycle):
  - done=1 and valid=1.
  - eq=e_r, gt=g_r, lt=~e_r & ~g_r. Exactly one of eq/gt/lt is 1.
  - Next edge: start=1 restarts a compare (back-to-back, behaves as IDLE accept); otherwise go to IDLE.
  - eq/gt/lt/valid hold in IDLE until the next accepted start.
- Latency: start accepted at edge 0 -> done high in the cycle following edge WIDTH. busy is high for WIDTH cycles.
- Throughput: one compare per WIDTH+1 cycles.
- Operand inputs a/b may change freely after capture.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, once the next e_r would be 0 (first differing bit found), go to DONE after that edge instead of continuing.
  - done latency = k cycles after the accepting edge, where k = 1-based position of the first differing bit counted from the MSB.
  - Equal operands still take WIDTH cycles.
  - Results are identical to the undefined case.
- Undefined: always WIDTH SHIFT cycles regardless of data.

Test Plan (WIDTH=8):
- Reset mid-operation:
  - Stimulus: rst=1 for 2 cycles, then start with a=8'h5A, b=8'h5A.
  - Required: done after 8 SHIFT cycles; eq=1, gt=0, lt=0, valid=1; busy=1 for exactly 8 cycles.
  - Then assert rst during cycle 3 of a new compare; all outputs 0 next cycle and no done strobe.
- MSB difference:
  - Stimulus: a=8'h80, b=8'h7F.
  - Required: gt=1, eq=0, lt=0.
  - With SERIAL_CMP_EARLY_EXIT_EN: done 1 cycle after accept. Without: done 8 cycles after accept.
- LSB difference:
  - Stimulus: a=8'h10, b=8'h11.
  - Required: lt=1; done 8 cycles after accept in both builds.
- Back-to-back compares:
  - Stimulus: start held high continuously; a=8'hFF/b=8'h00, then a=8'h00/b=8'hFF.
  - Required: second compare accepted in the DONE cycle; results gt=1 then lt=1; one done pulse per compare; no idle gap.
- Ignored start and capture:
  - Stimulus: start pulsed during SHIFT with different a/b; original operands a=8'h33, b=8'h33; inputs changed to a=8'h00 after capture.
  - Required: the extra start is ignored and the result is eq=1.
  - bit_a/bit_b sequence matches 0,0,1,1,0,0,1,1 (MSB first).
